// File: rtl/load_align_unit_if.sv
// rtl/load_align_unit_if.sv - MEM-stage load request, data-memory read port and write-back result bundle
interface load_align_unit_if;
  logic        ld_valid;
  logic [2:0]  funct3;
  logic [1:0]  remainder;
  logic [4:0]  rd_in;
  logic        hold;
  logic        dm_req;
  logic        dm_ack;
  logic [31:0] dm_r_data;
  logic [31:0] ld_data;
  logic [4:0]  ld_rd;
  logic        ld_done;
  logic        load_stall;
  logic        ld_err;

  modport slave (
    input  ld_valid, funct3, remainder, rd_in, hold, dm_ack, dm_r_data,
    output dm_req, ld_data, ld_rd, ld_done, load_stall, ld_err
  );

  modport master (
    output ld_valid, funct3, remainder, rd_in, hold, dm_ack, dm_r_data,
    input  dm_req, ld_data, ld_rd, ld_done, load_stall, ld_err
  );
endinterface

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load sequencer: issues the data-memory read, aligns/extends the word,
// holds the result for write-back and flags misaligned, illegal or timed-out loads
module load_align_unit #(
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  load_align_unit_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  logic [1:0]  state;
  logic        dm_req_q;
  logic        ld_done_q;
  logic        ld_err_q;
  logic [31:0] ld_data_q;
  logic [4:0]  ld_rd_q;
  logic [7:0]  wait_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  rem_q;
  logic [4:0]  rd_q;

  logic        legal;
  logic [31:0] shifted;
  logic [31:0] result;

  always_comb begin
    legal = 1'b0;
    case (bus.funct3)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~bus.remainder[0];
      3'b010:         legal = (bus.remainder == 2'b00);
      default:        legal = 1'b0;
    endcase
  end

  // The addressed byte/half is brought down to bit 0 before extension.
  always_comb begin
    shifted = bus.dm_r_data >> {rem_q, 3'b000};
    case (f3_q)
      3'b000:  result = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  result = {24'h0, shifted[7:0]};
      3'b001:  result = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  result = {16'h0, shifted[15:0]};
      default: result = bus.dm_r_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dm_req_q  <= 1'b0;
      ld_done_q <= 1'b0;
      ld_err_q  <= 1'b0;
      ld_data_q <= 32'h0;
      ld_rd_q   <= 5'h0;
      wait_cnt  <= 8'h0;
      f3_q      <= 3'h0;
      rem_q     <= 2'h0;
      rd_q      <= 5'h0;
    end else begin
      ld_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ld_valid) begin
            if (legal) begin
              state    <= WAIT;
              dm_req_q <= 1'b1;
              wait_cnt <= 8'h0;
              f3_q     <= bus.funct3;
              rem_q    <= bus.remainder;
              rd_q     <= bus.rd_in;
            end else begin
              ld_err_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          // A same-cycle ack wins over the timeout.
          if (bus.dm_ack) begin
            state     <= DONE;
            dm_req_q  <= 1'b0;
            ld_done_q <= 1'b1;
            ld_data_q <= result;
            ld_rd_q   <= rd_q;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == LAST_WAIT) begin
              state    <= IDLE;
              dm_req_q <= 1'b0;
              ld_err_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!bus.hold) begin
            ld_done_q <= 1'b0;
            if (bus.ld_valid && legal) begin
              state    <= WAIT;
              dm_req_q <= 1'b1;
              wait_cnt <= 8'h0;
              f3_q     <= bus.funct3;
              rem_q    <= bus.remainder;
              rd_q     <= bus.rd_in;
            end else begin
              // An illegal load offered on release is rejected like one offered in IDLE.
              state    <= IDLE;
              ld_err_q <= bus.ld_valid;
            end
          end
        end
        default: begin
          state     <= IDLE;
          dm_req_q  <= 1'b0;
          ld_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dm_req     = dm_req_q;
  assign bus.ld_done    = ld_done_q;
  assign bus.ld_err     = ld_err_q;
  assign bus.ld_data    = ld_data_q;
  assign bus.ld_rd      = ld_rd_q;
  assign bus.load_stall = rst & (((state == IDLE) & bus.ld_valid & legal) | (state == WAIT));

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - directed and randomized transaction-level checks of load_align_unit
module tb_load_align_unit;
  localparam int MW = 4;
  localparam int N  = 40;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  int   failed = 0;
  logic [31:0] exp_data = 32'h0;
  logic [4:0]  exp_rd   = 5'h0;

  load_align_unit_if bus ();

  load_align_unit #(.MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit is_legal(input logic [2:0] f, input logic [1:0] r);
    int ri = int'(r);
    case (f)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (ri % 2) == 0;
      3'd2:       return ri == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] r, input logic [31:0] d);
    longint unsigned w = longint'(d);
    longint v;
    repeat (int'(r)) w = w / 256;
    case (f)
      3'd0: begin v = longint'(w % 256);   if (v >= 128)   v = v - 256;   end
      3'd4: v = longint'(w % 256);
      3'd1: begin v = longint'(w % 65536); if (v >= 32768) v = v - 65536; end
      3'd5: v = longint'(w % 65536);
      default: v = longint'(d);
    endcase
    return 32'(v);
  endfunction

  // One load transaction from issue to write-back; ack_at >= MW means no ack (timeout).
  task automatic do_load(input logic [2:0] f, input logic [1:0] r, input logic [4:0] rd,
                         input logic [31:0] d, input int ack_at, input int hold_n,
                         input bit pre, input bit chain,
                         input logic [2:0] nf, input logic [1:0] nr, input logic [4:0] nrd);
    bit lg = is_legal(f, r);
    if (!pre) begin
      bus.ld_valid = 1'b1; bus.funct3 = f; bus.remainder = r; bus.rd_in = rd;
      bus.dm_ack = 1'($urandom); bus.dm_r_data = $urandom;
      #1;
      chk("stall_issue", bus.load_stall, lg);
      step();
    end
    bus.ld_valid = 1'b0;
    bus.dm_ack   = 1'b0;
    if (!lg) begin
      #1;
      chk("bad_err", bus.ld_err, 1'b1);
      chk("bad_req", bus.dm_req, 1'b0);
      chk("bad_data", bus.ld_data, exp_data);
      chk("bad_stall", bus.load_stall, 1'b0);
      step();
      chk("bad_err_clear", bus.ld_err, 1'b0);
      chk("bad_req2", bus.dm_req, 1'b0);
      return;
    end
    for (int w = 0; w < MW; w++) begin
      bus.dm_ack    = (w == ack_at);
      bus.dm_r_data = (w == ack_at) ? d : $urandom;
      bus.ld_valid  = 1'($urandom);
      bus.funct3    = 3'($urandom);
      bus.remainder = 2'($urandom);
      bus.rd_in     = 5'($urandom);
      #1;
      chk("wait_req", bus.dm_req, 1'b1);
      chk("wait_stall", bus.load_stall, 1'b1);
      chk("wait_done", bus.ld_done, 1'b0);
      chk("wait_err", bus.ld_err, 1'b0);
      chk("wait_data", bus.ld_data, exp_data);
      step();
      if (w == ack_at) break;
    end
    bus.dm_ack   = 1'b0;
    bus.ld_valid = 1'b0;
    if (ack_at >= MW) begin
      #1;
      chk("to_err", bus.ld_err, 1'b1);
      chk("to_req", bus.dm_req, 1'b0);
      chk("to_done", bus.ld_done, 1'b0);
      chk("to_data", bus.ld_data, exp_data);
      chk("to_stall", bus.load_stall, 1'b0);
      step();
      chk("to_err_clear", bus.ld_err, 1'b0);
      return;
    end
    exp_data = ref_load(f, r, d);
    exp_rd   = rd;
    for (int h = 0; h <= hold_n; h++) begin
      bus.hold      = (h < hold_n);
      bus.dm_ack    = 1'($urandom);
      bus.dm_r_data = $urandom;
      if (h < hold_n) begin
        bus.ld_valid = 1'($urandom); bus.funct3 = 3'($urandom);
        bus.remainder = 2'($urandom); bus.rd_in = 5'($urandom);
      end else begin
        bus.ld_valid = chain; bus.funct3 = nf; bus.remainder = nr; bus.rd_in = nrd;
      end
      #1;
      chk("done_flag", bus.ld_done, 1'b1);
      chk("done_data", bus.ld_data, exp_data);
      chk("done_rd", bus.ld_rd, exp_rd);
      chk("done_req", bus.dm_req, 1'b0);
      chk("done_err", bus.ld_err, 1'b0);
      step();
    end
    bus.hold = 1'b0; bus.ld_valid = 1'b0; bus.dm_ack = 1'b0;
    if (!chain) begin
      #1;
      chk("done_clear", bus.ld_done, 1'b0);
      chk("idle_req", bus.dm_req, 1'b0);
    end
  endtask

  logic [2:0]  rf [N];
  logic [1:0]  rr [N];
  logic [4:0]  rrd[N];
  logic [31:0] rdat[N];
  int          rack[N];
  int          rhold[N];

  initial begin
    bit pre;
    bit chain;
    rst = 1'b0;
    bus.ld_valid = 1'b1; bus.funct3 = 3'd0; bus.remainder = 2'd0; bus.rd_in = 5'd1;
    bus.hold = 1'b0; bus.dm_ack = 1'b0; bus.dm_r_data = 32'h0;
    #12;
    chk("rst_req", bus.dm_req, 1'b0);
    chk("rst_done", bus.ld_done, 1'b0);
    chk("rst_err", bus.ld_err, 1'b0);
    chk("rst_data", bus.ld_data, 32'h0);
    chk("rst_rd", bus.ld_rd, 5'h0);
    chk("rst_stall", bus.load_stall, 1'b0);
    step();
    rst = 1'b1;
    bus.ld_valid = 1'b0;
    step();

    do_load(3'd0, 2'd2, 5'd7,  32'h0080_0000, 1, 0, 0, 0, 3'd0, 2'd0, 5'd0);
    do_load(3'd5, 2'd2, 5'd3,  32'hBEEF_1234, 0, 0, 0, 0, 3'd0, 2'd0, 5'd0);
    do_load(3'd1, 2'd2, 5'd4,  32'hBEEF_1234, 0, 0, 0, 0, 3'd0, 2'd0, 5'd0);
    do_load(3'd2, 2'd1, 5'd5,  32'h1111_2222, 0, 0, 0, 0, 3'd0, 2'd0, 5'd0);
    do_load(3'd3, 2'd0, 5'd5,  32'h1111_2222, 0, 0, 0, 0, 3'd0, 2'd0, 5'd0);
    do_load(3'd5, 2'd3, 5'd5,  32'h1111_2222, 0, 0, 0, 0, 3'd0, 2'd0, 5'd0);
    do_load(3'd2, 2'd0, 5'd6,  32'hCAFE_F00D, MW, 0, 0, 0, 3'd0, 2'd0, 5'd0);
    do_load(3'd2, 2'd0, 5'd8,  32'h1234_5678, MW - 1, 0, 0, 0, 3'd0, 2'd0, 5'd0);
    do_load(3'd4, 2'd3, 5'd10, 32'h9A00_0000, 0, 3, 0, 1, 3'd1, 2'd0, 5'd11);
    do_load(3'd1, 2'd0, 5'd11, 32'h0000_8001, 2, 0, 1, 0, 3'd0, 2'd0, 5'd0);

    bus.ld_valid = 1'b1; bus.funct3 = 3'd2; bus.remainder = 2'd0; bus.rd_in = 5'd9;
    step();
    #1;
    chk("rw_req", bus.dm_req, 1'b1);
    rst = 1'b0;
    #1;
    chk("rw_req_drop", bus.dm_req, 1'b0);
    chk("rw_done", bus.ld_done, 1'b0);
    chk("rw_err", bus.ld_err, 1'b0);
    chk("rw_data", bus.ld_data, 32'h0);
    chk("rw_rd", bus.ld_rd, 5'h0);
    chk("rw_stall", bus.load_stall, 1'b0);
    step();
    rst = 1'b1;
    bus.ld_valid = 1'b0; bus.dm_ack = 1'b1; bus.dm_r_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rw_ack_ignored", bus.ld_done, 1'b0);
      chk("rw_req_idle", bus.dm_req, 1'b0);
      chk("rw_data_kept", bus.ld_data, 32'h0);
    end
    bus.dm_ack = 1'b0;
    exp_data = 32'h0;
    exp_rd   = 5'h0;

    for (int i = 0; i < N; i++) begin
      rf[i]    = 3'($urandom_range(0, 7));
      rr[i]    = 2'($urandom);
      rrd[i]   = 5'($urandom);
      rdat[i]  = $urandom;
      rack[i]  = $urandom_range(0, MW);
      rhold[i] = $urandom_range(0, 3);
    end
    pre = 1'b0;
    for (int i = 0; i < N; i++) begin
      chain = is_legal(rf[i], rr[i]) && (rack[i] < MW) && (i < N - 1) &&
              is_legal(rf[(i + 1) % N], rr[(i + 1) % N]) && ($urandom_range(0, 1) == 1);
      do_load(rf[i], rr[i], rrd[i], rdat[i], rack[i], rhold[i], pre, chain,
              rf[(i + 1) % N], rr[(i + 1) % N], rrd[(i + 1) % N]);
      pre = chain;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
